retire_stage: RTL and testbench
===============================

Name: retire_stage

Overview:
- N-wide in-order commit stage between the ROB head and the architectural back-end.
- Each cycle it selects the longest retirable prefix of the ROB head slots and pops that many from the ROB.
- It updates the architectural map table (AMT), releases old physical registers to the free list, and grants store commits to the store queue.
- Generalises the fixed 3-wide retire path with parametric width, store-credit back-pressure, mispredict recovery, sticky halt and a retired-instruction counter.

Parameters:
- WIDTH, 3, retire slots per cycle (1..8).
- ARC_REGS, 32, architectural registers; register 0 means no destination.
- PHY_REGS, 64, physical registers.
- Derived: ARC_W=$clog2(ARC_REGS), PHY_W=$clog2(PHY_REGS), CNT_W=$clog2(WIDTH+1).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- rob_valid  in  WIDTH  slot i holds a completed instruction (slot 0 = oldest).
- rob_is_store  in  WIDTH  slot is a store.
- rob_mispredict  in  WIDTH  slot is a mispredicted branch.
- rob_is_halt  in  WIDTH  slot is a halt.
- rob_arc_dst  in  WIDTH*ARC_W  architectural destination per slot.
- rob_phy_dst  in  WIDTH*PHY_W  new physical destination per slot.
- rob_phy_dst_old  in  WIDTH*PHY_W  previous mapping per slot.
- sq_credit  in  CNT_W  stores the store queue can commit this cycle.
- retire_count  out  CNT_W  number of head slots popped this cycle.
- retire_mask  out  WIDTH  per-slot retire, a contiguous prefix.
- fl_free_valid  out  WIDTH  slot's phy_dst_old is released.
- fl_free_phy  out  WIDTH*PHY_W  released register per slot.
- sq_commit_count  out  CNT_W  stores committed this cycle.
- recover  out  1  one-cycle pipeline flush/restore request.
- amt_out  out  ARC_REGS*PHY_W  architectural map table contents.
- halted  out  1  sticky halt status.
- retired_total  out  64  cumulative retired instructions.

Behaviour:
- Reset values:
  - AMT entry r = r.
  - halted=0, recover=0, retired_total=0.
  - Combinational outputs are all 0 in the reset cycle; no retire while reset is high.
  - Reset asserted mid-stream discards any pending recover.
- Retire condition for slot i (combinational, same cycle): retire[i] holds only when every one of the following is true.
  - rob_valid[i].
  - retire[i-1] for i>0.
  - Stores in slots 0..i do not exceed sq_credit.
  - halted=0 and recover=0.
  - No slot j<i has rob_mispredict or rob_is_halt set.
- A mispredict or halt slot itself retires, but terminates the prefix.
- retire_count = popcount(retire_mask).
- sq_commit_count = number of retiring stores.
- A store blocked by credit also blocks every younger slot; non-stores are never blocked by credit alone.
- fl_free_valid[i] = retire[i] and rob_arc_dst[i] != 0.
- fl_free_phy[i] = rob_phy_dst_old[i].
- AMT write at the edge: for each retiring slot with arc_dst != 0, AMT[arc_dst] <= phy_dst.
  - If several retiring slots target the same arc register, the highest-index slot wins.
  - Intermediate old mappings are still freed via their own phy_dst_old.
- amt_out reflects registered AMT state: updates are visible the cycle after retire.
- Mispredict: if a retiring slot has rob_mispredict, recover=1 for exactly the next cycle.
  - amt_out is already updated in that cycle, so consumers restore from amt_out while recover=1.
  - During recover, retire_count=0 and all free/commit outputs are 0.
- Halt: a retiring rob_is_halt slot sets halted=1 at the edge.
  - halted stays 1 until reset; retire_count=0 thereafter.
  - Halt has priority; no recover is raised for a slot that is both halt and mispredict.
- retired_total += retire_count each edge and wraps modulo 2^64.
- sq_credit values > WIDTH are treated as WIDTH.

Test Plan:
- WIDTH=3, all slots valid non-store, arc_dst=5/6/7, phy_dst=40/41/42, old=5/6/7.
  - Same cycle: retire_count=3, fl_free_phy={5,6,7}.
  - Next cycle: amt_out[5..7]={40,41,42}, retired_total=3.
- Slots {store, store, alu}, sq_credit=1:
  - retire_mask=001, sq_commit_count=1.
  - With sq_credit=2 the next cycle: mask=111.
- Slot1 mispredict, slot2 valid: mask=011.
  - Next cycle: recover=1 and retire_count=0 with all slots valid.
  - Cycle after: recover=0 and retire resumes.
- Slot0 and slot2 both write arc 3 (phy 50 then 52, old 3 then 50):
  - amt_out[3]=52.
  - fl_free frees 3 and 50.
- Slot0 arc_dst=0: fl_free_valid[0]=0, AMT unchanged, still counted in retire_count.
- Slot1 halt: mask=011, halted=1 next cycle and stays 1 for 10 cycles of valid input.
  - Reset then restores AMT identity, halted=0, retired_total=0.

Source files
------------

// File: rtl/retire_stage.sv
// N-wide in-order retire stage: pops the longest retirable prefix of the ROB head,
// updates the architectural map table, frees old mappings and grants store commits.
module retire_stage #(
  parameter int WIDTH    = 3,
  parameter int ARC_REGS = 32,
  parameter int PHY_REGS = 64,
  localparam int ARC_W   = $clog2(ARC_REGS),
  localparam int PHY_W   = $clog2(PHY_REGS),
  localparam int CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          rob_valid,
  input  logic [WIDTH-1:0]          rob_is_store,
  input  logic [WIDTH-1:0]          rob_mispredict,
  input  logic [WIDTH-1:0]          rob_is_halt,
  input  logic [WIDTH*ARC_W-1:0]    rob_arc_dst,
  input  logic [WIDTH*PHY_W-1:0]    rob_phy_dst,
  input  logic [WIDTH*PHY_W-1:0]    rob_phy_dst_old,
  input  logic [CNT_W-1:0]          sq_credit,
  output logic [CNT_W-1:0]          retire_count,
  output logic [WIDTH-1:0]          retire_mask,
  output logic [WIDTH-1:0]          fl_free_valid,
  output logic [WIDTH*PHY_W-1:0]    fl_free_phy,
  output logic [CNT_W-1:0]          sq_commit_count,
  output logic                      recover,
  output logic [ARC_REGS*PHY_W-1:0] amt_out,
  output logic                      halted,
  output logic [63:0]               retired_total
);

  // Handshake: the ROB presents completed head slots on rob_valid; retire_mask is the
  // same-cycle pop acknowledgement and is always a contiguous prefix from slot 0.

  logic [PHY_W-1:0] amt_q [ARC_REGS];
  logic [PHY_W-1:0] amt_d [ARC_REGS];
  logic             halted_q, halted_d;
  logic             recover_q, recover_d;
  logic [63:0]      total_q, total_d;

  logic [CNT_W-1:0] credit;
  logic [CNT_W-1:0] stores;
  logic [CNT_W-1:0] stores_try;
  logic             open;
  logic [ARC_W-1:0] slot_arc;

  always_comb begin
    retire_mask     = '0;
    retire_count    = '0;
    fl_free_valid   = '0;
    fl_free_phy     = '0;
    sq_commit_count = '0;
    stores          = '0;
    stores_try      = '0;
    slot_arc        = '0;
    credit          = (sq_credit > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : sq_credit;
    open            = !reset && !halted_q && !recover_q;
    for (int i = 0; i < WIDTH; i++) begin
      stores_try = stores + CNT_W'(rob_is_store[i]);
      slot_arc   = rob_arc_dst[i*ARC_W +: ARC_W];
      if (open && rob_valid[i] && (stores_try <= credit)) begin
        retire_mask[i] = 1'b1;
        retire_count   = retire_count + CNT_W'(1);
        stores         = stores_try;
        if (slot_arc != '0) begin
          fl_free_valid[i]               = 1'b1;
          fl_free_phy[i*PHY_W +: PHY_W]  = rob_phy_dst_old[i*PHY_W +: PHY_W];
        end
        // A mispredict or halt retires itself but ends the prefix.
        open = !rob_mispredict[i] && !rob_is_halt[i];
      end else begin
        open = 1'b0;
      end
    end
    sq_commit_count = stores;
  end

  always_comb begin
    for (int r = 0; r < ARC_REGS; r++) begin
      amt_d[r] = amt_q[r];
    end
    halted_d  = halted_q;
    recover_d = 1'b0;
    total_d   = total_q + 64'(retire_count);
    // Ascending slot order lets the youngest writer of an arc register win.
    for (int i = 0; i < WIDTH; i++) begin
      if (retire_mask[i]) begin
        if (rob_arc_dst[i*ARC_W +: ARC_W] != '0) begin
          amt_d[rob_arc_dst[i*ARC_W +: ARC_W]] = rob_phy_dst[i*PHY_W +: PHY_W];
        end
        if (rob_is_halt[i]) begin
          halted_d = 1'b1;
        end else if (rob_mispredict[i]) begin
          recover_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < ARC_REGS; r++) begin
        amt_q[r] <= PHY_W'(r);
      end
      halted_q  <= 1'b0;
      recover_q <= 1'b0;
      total_q   <= '0;
    end else begin
      for (int r = 0; r < ARC_REGS; r++) begin
        amt_q[r] <= amt_d[r];
      end
      halted_q  <= halted_d;
      recover_q <= recover_d;
      total_q   <= total_d;
    end
  end

  always_comb begin
    amt_out = '0;
    for (int r = 0; r < ARC_REGS; r++) begin
      amt_out[r*PHY_W +: PHY_W] = amt_q[r];
    end
  end

  // A recover pending when reset arrives is dropped immediately.
  assign recover       = recover_q && !reset;
  assign halted        = halted_q;
  assign retired_total = total_q;

endmodule

// File: tb/tb_retire_stage.sv
// Directed bench for retire_stage: driver pushes expected responses, a monitor
// pops and compares them on the falling edge.
module tb_retire_stage;

  localparam int WIDTH = 3;
  localparam int ARC_REGS = 32;
  localparam int PHY_W = 6;
  localparam int ARC_W = 5;
  localparam int CNT_W = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [WIDTH-1:0] rob_valid = '0, rob_is_store = '0, rob_mispredict = '0, rob_is_halt = '0;
  logic [WIDTH*ARC_W-1:0] rob_arc_dst = '0;
  logic [WIDTH*PHY_W-1:0] rob_phy_dst = '0, rob_phy_dst_old = '0;
  logic [CNT_W-1:0] sq_credit = '0;
  logic [CNT_W-1:0] retire_count, sq_commit_count;
  logic [WIDTH-1:0] retire_mask, fl_free_valid;
  logic [WIDTH*PHY_W-1:0] fl_free_phy;
  logic recover, halted;
  logic [ARC_REGS*PHY_W-1:0] amt_out;
  logic [63:0] retired_total;

  retire_stage dut (
    .clock(clock), .reset(reset),
    .rob_valid(rob_valid), .rob_is_store(rob_is_store),
    .rob_mispredict(rob_mispredict), .rob_is_halt(rob_is_halt),
    .rob_arc_dst(rob_arc_dst), .rob_phy_dst(rob_phy_dst),
    .rob_phy_dst_old(rob_phy_dst_old), .sq_credit(sq_credit),
    .retire_count(retire_count), .retire_mask(retire_mask),
    .fl_free_valid(fl_free_valid), .fl_free_phy(fl_free_phy),
    .sq_commit_count(sq_commit_count), .recover(recover),
    .amt_out(amt_out), .halted(halted), .retired_total(retired_total)
  );

  // clock / reset
  always #5 clock = ~clock;

  typedef struct packed {
    logic [CNT_W-1:0]          rc;
    logic [WIDTH-1:0]          mask;
    logic [WIDTH-1:0]          fv;
    logic [WIDTH*PHY_W-1:0]    fp;
    logic [CNT_W-1:0]          sc;
    logic                      rec;
    logic                      hlt;
    logic [63:0]               tot;
    logic [ARC_REGS*PHY_W-1:0] amt;
  } exp_t;

  exp_t exp_q[$];

  int n_total = 0;
  int n_pass = 0;

  // Hand-maintained architectural state expected to be visible in the next cycle.
  logic [PHY_W-1:0] exp_amt [ARC_REGS];
  logic             exp_hlt;
  logic             exp_rec;
  logic [63:0]      exp_tot;

  task automatic reset_model();
    for (int r = 0; r < ARC_REGS; r++) exp_amt[r] = PHY_W'(r);
    exp_hlt = 1'b0;
    exp_rec = 1'b0;
    exp_tot = '0;
  endtask

  function automatic logic [WIDTH*ARC_W-1:0] pa(input int a0, input int a1, input int a2);
    return {ARC_W'(a2), ARC_W'(a1), ARC_W'(a0)};
  endfunction

  function automatic logic [WIDTH*PHY_W-1:0] pp(input int p0, input int p1, input int p2);
    return {PHY_W'(p2), PHY_W'(p1), PHY_W'(p0)};
  endfunction

  // driver
  task automatic cyc(input logic rst, input logic [2:0] v, input logic [2:0] st,
                     input logic [2:0] mp, input logic [2:0] ht,
                     input logic [WIDTH*ARC_W-1:0] arc, input logic [WIDTH*PHY_W-1:0] phy,
                     input logic [WIDTH*PHY_W-1:0] old, input logic [CNT_W-1:0] cred,
                     input logic [CNT_W-1:0] e_rc, input logic [2:0] e_mask,
                     input logic [2:0] e_fv, input logic [WIDTH*PHY_W-1:0] e_fp,
                     input logic [CNT_W-1:0] e_sc);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rst;
    rob_valid = v; rob_is_store = st; rob_mispredict = mp; rob_is_halt = ht;
    rob_arc_dst = arc; rob_phy_dst = phy; rob_phy_dst_old = old; sq_credit = cred;
    e.rc = e_rc; e.mask = e_mask; e.fv = e_fv; e.fp = e_fp; e.sc = e_sc;
    e.rec = exp_rec; e.hlt = exp_hlt; e.tot = exp_tot;
    for (int r = 0; r < ARC_REGS; r++) e.amt[r*PHY_W +: PHY_W] = exp_amt[r];
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [ARC_REGS*PHY_W-1:0] act,
                     input logic [ARC_REGS*PHY_W-1:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", nm, act, req);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      logic [WIDTH*PHY_W-1:0] fmask;
      e = exp_q.pop_front();
      fmask = '0;
      for (int i = 0; i < WIDTH; i++) if (e.fv[i]) fmask[i*PHY_W +: PHY_W] = '1;
      chk("retire_count", 192'(retire_count), 192'(e.rc));
      chk("retire_mask", 192'(retire_mask), 192'(e.mask));
      chk("fl_free_valid", 192'(fl_free_valid), 192'(e.fv));
      chk("fl_free_phy", 192'(fl_free_phy & fmask), 192'(e.fp & fmask));
      chk("sq_commit_count", 192'(sq_commit_count), 192'(e.sc));
      chk("recover", 192'(recover), 192'(e.rec));
      chk("halted", 192'(halted), 192'(e.hlt));
      chk("retired_total", 192'(retired_total), 192'(e.tot));
      chk("amt_out", amt_out, e.amt);
    end
  end

  initial begin
    reset_model();
    // reset cycle: all valid, nothing may retire
    cyc(1, 3'b111, 0, 0, 0, pa(5,6,7), pp(40,41,42), pp(5,6,7), 3, 0, 3'b000, 3'b000, 0, 0);
    // full-width ALU retire
    cyc(0, 3'b111, 0, 0, 0, pa(5,6,7), pp(40,41,42), pp(5,6,7), 0, 3, 3'b111, 3'b111, pp(5,6,7), 0);
    exp_amt[5] = 40; exp_amt[6] = 41; exp_amt[7] = 42; exp_tot = 3;
    // {store, store, alu} with one credit
    cyc(0, 3'b111, 3'b011, 0, 0, pa(1,2,8), pp(10,11,12), pp(1,2,8), 1, 1, 3'b001, 3'b001, pp(1,0,0), 1);
    exp_amt[1] = 10; exp_tot = 4;
    // same group with two credits
    cyc(0, 3'b111, 3'b011, 0, 0, pa(1,2,8), pp(10,11,12), pp(1,2,8), 2, 3, 3'b111, 3'b111, pp(1,2,8), 2);
    exp_amt[2] = 11; exp_amt[8] = 12; exp_tot = 7;
    // blocked store in slot 1 stops slot 2
    cyc(0, 3'b111, 3'b010, 0, 0, pa(9,10,11), pp(20,21,22), pp(9,10,11), 0, 1, 3'b001, 3'b001, pp(9,0,0), 0);
    exp_amt[9] = 20; exp_tot = 8;
    // mispredict in slot 1
    cyc(0, 3'b111, 0, 3'b010, 0, pa(12,13,14), pp(30,31,32), pp(12,13,14), 0, 2, 3'b011, 3'b011, pp(12,13,0), 0);
    exp_amt[12] = 30; exp_amt[13] = 31; exp_tot = 10; exp_rec = 1;
    cyc(0, 3'b111, 0, 0, 0, pa(15,16,17), pp(33,34,35), pp(15,16,17), 0, 0, 3'b000, 3'b000, 0, 0);
    exp_rec = 0;
    cyc(0, 3'b111, 0, 0, 0, pa(15,16,17), pp(33,34,35), pp(15,16,17), 0, 3, 3'b111, 3'b111, pp(15,16,17), 0);
    exp_amt[15] = 33; exp_amt[16] = 34; exp_amt[17] = 35; exp_tot = 13;
    // slots 0 and 2 both write arc 3, slot 1 has no destination
    cyc(0, 3'b111, 0, 0, 0, pa(3,0,3), pp(50,51,52), pp(3,51,50), 0, 3, 3'b111, 3'b101, pp(3,0,50), 0);
    exp_amt[3] = 52; exp_tot = 16;
    // slot 0 arc_dst 0 still counts
    cyc(0, 3'b011, 0, 0, 0, pa(0,4,0), pp(60,44,0), pp(61,4,0), 0, 2, 3'b011, 3'b010, pp(0,4,0), 0);
    exp_amt[4] = 44; exp_tot = 18;
    // invalid slot 1 breaks the prefix
    cyc(0, 3'b101, 0, 0, 0, pa(18,0,22), pp(45,0,46), pp(18,0,22), 0, 1, 3'b001, 3'b001, pp(18,0,0), 0);
    exp_amt[18] = 45; exp_tot = 19;
    // halt in slot 1
    cyc(0, 3'b111, 0, 0, 3'b010, pa(19,20,21), pp(46,47,48), pp(19,20,21), 0, 2, 3'b011, 3'b011, pp(19,20,0), 0);
    exp_amt[19] = 46; exp_amt[20] = 47; exp_tot = 21; exp_hlt = 1;
    for (int k = 0; k < 10; k++)
      cyc(0, 3'b111, 0, 0, 0, pa(22,23,24), pp(1,2,3), pp(22,23,24), 3, 0, 3'b000, 3'b000, 0, 0);
    // reset restores identity map and clears status
    cyc(1, 3'b111, 0, 0, 0, pa(22,23,24), pp(1,2,3), pp(22,23,24), 3, 0, 3'b000, 3'b000, 0, 0);
    reset_model();
    cyc(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0);
    // pending recover dropped by reset
    cyc(0, 3'b001, 0, 3'b001, 0, 0, 0, 0, 0, 1, 3'b001, 3'b000, 0, 0);
    exp_tot = 1; exp_rec = 1;
    exp_rec = 0;
    cyc(1, 3'b111, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0);
    exp_tot = 0;
    cyc(0, 3'b111, 0, 0, 0, 0, 0, 0, 0, 3, 3'b111, 3'b000, 0, 0);
    exp_tot = 3;
    // halt and mispredict on the same slot: halt only
    cyc(0, 3'b111, 0, 3'b001, 3'b001, 0, 0, 0, 0, 1, 3'b001, 3'b000, 0, 0);
    exp_tot = 4; exp_hlt = 1;
    cyc(0, 3'b111, 0, 0, 0, 0, 0, 0, 3, 0, 3'b000, 3'b000, 0, 0);

    for (int k = 0; k < 5; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clock);
    end
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain got=%0d expected=0 pending", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
